// File: rtl/udp_gen_pkg.sv
// Shared definitions for the UDP datagram generator: FSM states, header
// constants and the payload length clamp.
package udp_gen_pkg;

  localparam int         UDP_HDR_BYTES = 8;
  localparam int         MIN_PAYLOAD   = 4;
  localparam logic [7:0] DEFAULT_TTL   = 8'd64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_GAP
  } gen_state_t;

  // The sequence number occupies the first four payload bytes, so shorter
  // payloads are stretched up to that size.
  function automatic logic [15:0] clampLen(input logic [15:0] len,
                                           input logic [15:0] maxLen);
    if (len < 16'(MIN_PAYLOAD)) begin
      return 16'(MIN_PAYLOAD);
    end else if (len > maxLen) begin
      return maxLen;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/udp_pkt_gen.sv
// UDP datagram generator: emits a header handshake followed by a payload
// stream carrying a big-endian sequence number, then idles for a gap.
module udp_pkt_gen
  import udp_gen_pkg::*;
#(
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DEST_PORT   = 16'd1234,
  parameter int          MAX_PAYLOAD = 1472
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] local_ip,
  input  logic [31:0] dest_ip,
  input  logic [15:0] payload_len,
  input  logic [15:0] gap_cycles,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic [5:0]  hdr_ip_dscp,
  output logic [1:0]  hdr_ip_ecn,
  output logic [7:0]  hdr_ip_ttl,
  output logic [31:0] hdr_ip_source_ip,
  output logic [31:0] hdr_ip_dest_ip,
  output logic [15:0] hdr_source_port,
  output logic [15:0] hdr_dest_port,
  output logic [15:0] hdr_length,
  output logic [15:0] hdr_checksum,
  output logic [7:0]  tdata,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast,
  output logic        tuser,
  output logic        busy,
  output logic [31:0] pkt_count
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  gen_state_t  r_state;
  gen_state_t  w_nextState;
  logic [31:0] r_srcIp;
  logic [31:0] r_dstIp;
  logic [15:0] r_len;
  logic [31:0] r_seqNum;
  logic [31:0] r_pktCount;
  logic [15:0] r_byteIdx;
  logic [15:0] r_gapCnt;

  logic        w_gapDone;
  logic        w_latch;
  logic        w_dataFire;
  logic        w_lastByte;
  logic [15:0] w_gapLoad;
  logic [7:0]  w_payloadByte;

  assign w_gapDone  = (r_state == ST_GAP) && (r_gapCnt == 16'd0);
  assign w_latch    = enable && ((r_state == ST_IDLE) || w_gapDone);
  assign w_dataFire = (r_state == ST_PAYLOAD) && tready;
  assign w_lastByte = (r_byteIdx == r_len - 16'd1);
  // A zero gap still spends one cycle in GAP, hence the floor of one.
  assign w_gapLoad  = (gap_cycles == 16'd0) ? 16'd0 : gap_cycles - 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (enable) w_nextState = ST_HDR;
      ST_HDR:     if (hdr_ready) w_nextState = ST_PAYLOAD;
      ST_PAYLOAD: if (tready && w_lastByte) w_nextState = ST_GAP;
      ST_GAP:     if (r_gapCnt == 16'd0) w_nextState = enable ? ST_HDR : ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_srcIp    <= '0;
      r_dstIp    <= '0;
      r_len      <= '0;
      r_seqNum   <= '0;
      r_pktCount <= '0;
      r_byteIdx  <= '0;
      r_gapCnt   <= '0;
    end else begin
      if (w_latch) begin
        r_srcIp <= local_ip;
        r_dstIp <= dest_ip;
        r_len   <= clampLen(payload_len, MAX_LEN);
      end
      if (w_dataFire) begin
        if (w_lastByte) begin
          r_byteIdx  <= '0;
          r_seqNum   <= r_seqNum + 32'd1;
          r_pktCount <= r_pktCount + 32'd1;
          r_gapCnt   <= w_gapLoad;
        end else begin
          r_byteIdx <= r_byteIdx + 16'd1;
        end
      end
      if ((r_state == ST_GAP) && (r_gapCnt != 16'd0)) begin
        r_gapCnt <= r_gapCnt - 16'd1;
      end
    end
  end

  always_comb begin
    w_payloadByte = r_byteIdx[7:0];
    if (r_byteIdx[15:2] == 14'd0) begin
      case (r_byteIdx[1:0])
        2'd0:    w_payloadByte = r_seqNum[31:24];
        2'd1:    w_payloadByte = r_seqNum[23:16];
        2'd2:    w_payloadByte = r_seqNum[15:8];
        default: w_payloadByte = r_seqNum[7:0];
      endcase
    end
  end

  // Outputs are forced to zero combinationally so that reset silences the
  // interfaces in the same cycle it is asserted.
  always_comb begin
    hdr_valid        = 1'b0;
    hdr_ip_dscp      = '0;
    hdr_ip_ecn       = '0;
    hdr_ip_ttl       = '0;
    hdr_ip_source_ip = '0;
    hdr_ip_dest_ip   = '0;
    hdr_source_port  = '0;
    hdr_dest_port    = '0;
    hdr_length       = '0;
    hdr_checksum     = '0;
    tdata            = '0;
    tvalid           = 1'b0;
    tlast            = 1'b0;
    tuser            = 1'b0;
    busy             = 1'b0;
    pkt_count        = r_pktCount;
    if (!reset) begin
      hdr_valid        = (r_state == ST_HDR);
      hdr_ip_ttl       = DEFAULT_TTL;
      hdr_ip_source_ip = r_srcIp;
      hdr_ip_dest_ip   = r_dstIp;
      hdr_source_port  = SRC_PORT;
      hdr_dest_port    = DEST_PORT;
      hdr_length       = r_len + 16'(UDP_HDR_BYTES);
      tdata            = w_payloadByte;
      tvalid           = (r_state == ST_PAYLOAD);
      tlast            = (r_state == ST_PAYLOAD) && w_lastByte;
      busy             = (r_state == ST_HDR) || (r_state == ST_PAYLOAD);
    end
  end

endmodule
